// File: rtl/deco_pkg.sv
// Shared types and default geometry for the turbo decoder frame ingress.
// The FSM state enum and the frame width helper are used by the top level.
package deco_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StCommit, StGap} deco_state_e;

    localparam int unsigned DEF_BEAT_W = 21;
    localparam int unsigned DEF_BEATS  = 4;
    localparam int unsigned DEF_OUT_W  = 5;
    localparam int unsigned DEF_DEPTH  = 2;

    function automatic int unsigned frame_w(input int unsigned beat_w, input int unsigned beats);
        return beat_w * beats;
    endfunction

endpackage

// File: rtl/deco_frame_fifo.sv
// DEPTH x WIDTH synchronous FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle. rdata reads as zero while empty.
module deco_frame_fifo #(
    parameter int unsigned WIDTH = 84,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/deco_frame_ingress.sv
// Beat-wise frame deserialiser, frame FIFO and result return path for the decoder core.
// Optional DECO_DROP_CNT_EN adds an 8-bit saturating dropped-frame counter on drop_cnt_o.
module deco_frame_ingress
    import deco_pkg::*;
#(
    parameter int unsigned BEAT_W = DEF_BEAT_W,
    parameter int unsigned BEATS  = DEF_BEATS,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                               clk_p_i,
    input  logic                               reset_n_i,
    input  logic                               start_i,
    input  logic [BEAT_W-1:0]                  data_i,
    output logic [frame_w(BEAT_W, BEATS)-1:0]  frame_o,
    output logic                               frame_valid_o,
    input  logic                               frame_ready_i,
    input  logic [OUT_W-1:0]                   res_i,
    input  logic                               res_valid_i,
    output logic [OUT_W-1:0]                   data_o,
    output logic                               done_o,
    output logic                               abort_o,
    output logic                               ovf_o
`ifdef DECO_DROP_CNT_EN
    ,
    output logic [7:0]                         drop_cnt_o
`endif
);

    localparam int unsigned FRAME_W = frame_w(BEAT_W, BEATS);
    localparam int unsigned CNT_W   = $clog2(BEATS);
    localparam int unsigned OUTST_W = $clog2(DEPTH) + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (BEATS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("deco_frame_ingress: BEATS must be >= 2, DEPTH a power of two >= 2");
    end

    deco_state_e        state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FRAME_W-1:0] asm_q;
    logic               load_beat, push_req, abort_d, abort_q;
    logic               fifo_full, fifo_empty, pop, drop;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               res_accept, res_orphan;
    logic [OUT_W-1:0]   data_q;
    logic               done_q, ovf_q;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StLoad;
            StLoad: begin
                if (!start_i)                      state_d = StIdle;
                else if (beat_cnt_q == LAST_BEAT)  state_d = StCommit;
            end
            StCommit: state_d = start_i ? StGap : StIdle;
            StGap:    if (!start_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        load_beat  = 1'b0;
        push_req   = 1'b0;
        abort_d    = 1'b0;
        beat_cnt_d = '0;
        unique case (state_q)
            StIdle:   load_beat = start_i;
            StLoad: begin
                load_beat = start_i;
                abort_d   = ~start_i;
            end
            StCommit: begin
                push_req = start_i;
                abort_d  = ~start_i;
            end
            default: ;
        endcase
        // Counter returns to zero on commit, abort or idle so beat 0 lands in the LSBs.
        if (load_beat && beat_cnt_q != LAST_BEAT) beat_cnt_d = beat_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            abort_q    <= abort_d;
            for (int b = 0; b < BEATS; b++) begin
                if (load_beat && beat_cnt_q == CNT_W'(b)) asm_q[b*BEAT_W +: BEAT_W] <= data_i;
            end
        end
    end

    deco_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_p_i),
        .rst_n (reset_n_i),
        .push  (push_req),
        .wdata (asm_q),
        .pop   (pop),
        .rdata (frame_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign frame_valid_o = ~fifo_empty;
    assign pop           = frame_valid_o & frame_ready_i;
    assign drop          = push_req & fifo_full & ~pop;
    assign res_accept    = res_valid_i & (outst_q != '0);
    assign res_orphan    = res_valid_i & (outst_q == '0);

    always_comb begin
        case ({pop, res_accept})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            outst_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            done_q  <= res_accept;
            if (res_accept)          data_q <= res_i;
            if (drop || res_orphan)  ovf_q  <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign done_o  = done_q;
    assign abort_o = abort_q;
    assign ovf_o   = ovf_q;

`ifdef DECO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i)                        drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
